dm_lsu: RTL

Load/store initiator in the CPU MEM stage that drives the data memory's word-wide port (`mem_addr`, `mem_wdata`, `mem_we`, `mem_pc`, `mem_rdata`). It converts lw/lh/lhu/lb/lbu/sw/sh/sb requests into memory cycles and returns aligned, extended load data. The data memory writes the full word whenever any `mem_we` bit is set, so sub-word stores run as read-modify-write sequences. `busy` stalls the pipeline for the duration of each access.

---
 rtl/dm_lsu.sv | 118 +++++++++++
 1 files changed

// File: rtl/dm_lsu.sv
// dm_lsu: MEM-stage load/store initiator; sub-word stores run as read-modify-write.
// Optional LSU_ADDR_EXC_EN: misalignment / out-of-range checks at accept with AdEL/AdES response.
module dm_lsu #(
  parameter int unsigned DM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  input  logic [2:0]  i_req_op,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [31:0] i_req_pc,
  output logic        o_busy,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_exc,
  output logic [4:0]  o_exc_code,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_we,
  output logic [31:0] o_mem_pc,
  input  logic [31:0] i_mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
  state_t r_state, w_next;
  logic [2:0]  r_op;
  logic [31:0] r_addr, r_wdata, r_pc, r_data;
  logic        w_load, w_sw, w_sh, w_sb, w_exc, w_accept;
  logic [31:0] w_shr, w_load_data, w_mask, w_ins, w_merge;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  logic [3:0]  w_be;
  if (DM_WORDS == 0 || DM_WORDS > 32'h3FFF_FFFF) begin : g_bad_depth
    $error("dm_lsu: DM_WORDS must be 1 .. 2^30-1");
  end
  assign w_accept = r_state == IDLE && i_req_valid;
  assign w_load   = r_op < 3'd5;
  assign w_sw     = r_op == 3'd5;
  assign w_sh     = r_op == 3'd6;
  assign w_sb     = r_op == 3'd7;
  assign w_shr    = i_mem_rdata >> {r_addr[1:0], 3'b000};
  assign w_byte   = w_shr[7:0];
  assign w_half   = r_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
  assign w_load_data = r_op == 3'd0 ? i_mem_rdata :
                       r_op == 3'd1 ? {{16{w_half[15]}}, w_half} :
                       r_op == 3'd2 ? {16'b0, w_half} :
                       r_op == 3'd3 ? {{24{w_byte[7]}}, w_byte} : {24'b0, w_byte};
  // merge: keep the old word outside the target lanes, replicate the store data inside them
  assign w_mask  = w_sb ? 32'hFF << {r_addr[1:0], 3'b000} : r_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
  assign w_ins   = w_sb ? {4{r_wdata[7:0]}} : {2{r_wdata[15:0]}};
  assign w_merge = (i_mem_rdata & ~w_mask) | (w_ins & w_mask);
  assign w_be    = w_sb ? 4'b0001 << r_addr[1:0] : r_addr[1] ? 4'b1100 : 4'b0011;
`ifdef LSU_ADDR_EXC_EN
  localparam logic [31:0] BYTES = 32'(4 * DM_WORDS);
  logic       r_exc;
  logic [4:0] r_exc_code;
  assign w_exc = ((i_req_op == 3'd0 || i_req_op == 3'd5) && i_req_addr[1:0] != 2'b00) ||
                 ((i_req_op == 3'd1 || i_req_op == 3'd2 || i_req_op == 3'd6) && i_req_addr[0]) ||
                 i_req_addr >= BYTES;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_exc      <= 1'b0;
      r_exc_code <= '0;
    end else if (w_accept) begin
      r_exc      <= w_exc;
      r_exc_code <= i_req_op >= 3'd5 ? 5'd5 : 5'd4;
    end
  end
  assign o_exc      = r_state == RESP && r_exc;
  assign o_exc_code = o_exc ? r_exc_code : 5'd0;
`else
  assign w_exc      = 1'b0;
  assign o_exc      = 1'b0;
  assign o_exc_code = 5'd0;
`endif
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next      = r_state;
    o_mem_we    = 4'b0000;
    o_mem_wdata = 32'h0;
    case (r_state)
      IDLE:   w_next = !i_req_valid ? IDLE : w_exc ? RESP : ACCESS;
      ACCESS: begin
        w_next      = (w_sb || w_sh) ? WRITE : RESP;
        o_mem_we    = w_sw ? 4'b1111 : 4'b0000;
        o_mem_wdata = w_sw ? r_wdata : 32'h0;
      end
      WRITE: begin
        w_next      = RESP;
        o_mem_we    = w_be;
        o_mem_wdata = r_data;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_pc    <= '0;
      r_data  <= '0;
    end else if (w_accept) begin
      r_op    <= i_req_op;
      r_addr  <= i_req_addr;
      r_wdata <= i_req_wdata;
      r_pc    <= i_req_pc;
      r_data  <= '0;
    end else if (r_state == ACCESS) begin
      r_data  <= w_load ? w_load_data : w_merge;
    end
  end
  assign o_busy       = r_state != IDLE;
  assign o_resp_valid = r_state == RESP;
  assign o_resp_rdata = (o_resp_valid && w_load) ? r_data : 32'h0;
  assign o_mem_addr   = o_busy ? {r_addr[31:2], 2'b00} : 32'h0;
  assign o_mem_pc     = o_busy ? r_pc : 32'h0;
endmodule
